// File: rtl/sram_1rw_port_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter:
// request-type encoding and the transaction FSM state encoding.
package sram_1rw_port_arbiter_pkg;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Index of the granted port for a one-hot two-bit grant vector.
    function automatic logic grant_index(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/sram_1rw_port_arbiter_rr_arbiter_2.sv
// Two-input round-robin arbiter: combinational one-hot grant, priority
// pointer moves to the other port whenever a grant is actually consumed.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_val,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        case (i_val)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Winner drops to lowest priority: port 0 winning points ptr at port 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (i_en && (o_grant != 2'b00)) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/sram_1rw_port_arbiter.sv
// Shares one external 1rw SRAM (1-cycle read latency) between two val/rdy
// requesters; one transaction in flight, every request gets a response.
module sram_1rw_port_arbiter
    import sram_1rw_port_arbiter_pkg::*;
#(
    parameter  int p_data_nbits  = 32,
    parameter  int p_num_entries = 256,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic                     req0_type,
    input  logic [c_addr_nbits-1:0]  req0_addr,
    input  logic [p_data_nbits-1:0]  req0_data,
    input  logic [c_data_nbytes-1:0] req0_byte_en,

    output logic                     resp0_val,
    input  logic                     resp0_rdy,
    output logic                     resp0_type,
    output logic [p_data_nbits-1:0]  resp0_data,

    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic                     req1_type,
    input  logic [c_addr_nbits-1:0]  req1_addr,
    input  logic [p_data_nbits-1:0]  req1_data,
    input  logic [c_data_nbytes-1:0] req1_byte_en,

    output logic                     resp1_val,
    input  logic                     resp1_rdy,
    output logic                     resp1_type,
    output logic [p_data_nbits-1:0]  resp1_data,

    output logic                     sram_read_en,
    output logic [c_addr_nbits-1:0]  sram_read_addr,
    input  logic [p_data_nbits-1:0]  sram_read_data,
    output logic                     sram_write_en,
    output logic [c_data_nbytes-1:0] sram_write_byte_en,
    output logic [c_addr_nbits-1:0]  sram_write_addr,
    output logic [p_data_nbits-1:0]  sram_write_data
);

    state_e                    r_state;
    state_e                    w_next_state;
    logic                      r_owner;
    logic                      r_type;
    logic [p_data_nbits-1:0]   r_resp_data;

    logic [1:0]                w_grant;
    logic [1:0]                w_rdy;
    logic [1:0]                w_resp_val;
    logic                      w_idle;
    logic                      w_fire;
    logic                      w_sel;
    logic                      w_type;
    logic [c_addr_nbits-1:0]   w_addr;
    logic [p_data_nbits-1:0]   w_data;
    logic [c_data_nbytes-1:0]  w_byte_en;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_val   ({req1_val, req0_val}),
        .i_en    (w_fire),
        .o_grant (w_grant)
    );

    // Requests are only accepted in IDLE and never while reset is held.
    assign w_idle = (r_state == ST_IDLE) && !reset;
    assign w_rdy  = w_idle ? w_grant : 2'b00;
    assign w_fire = |w_rdy;
    assign w_sel  = grant_index(w_grant);

    assign req0_rdy = w_rdy[0];
    assign req1_rdy = w_rdy[1];

    assign w_type    = w_sel ? req1_type    : req0_type;
    assign w_addr    = w_sel ? req1_addr    : req0_addr;
    assign w_data    = w_sel ? req1_data    : req0_data;
    assign w_byte_en = w_sel ? req1_byte_en : req0_byte_en;

    // SRAM fields are forced to zero outside a fire so nothing leaks X.
    assign sram_read_en       = w_fire && (w_type == REQ_READ);
    assign sram_write_en      = w_fire && (w_type == REQ_WRITE);
    assign sram_read_addr     = w_fire ? w_addr    : '0;
    assign sram_write_addr    = w_fire ? w_addr    : '0;
    assign sram_write_data    = w_fire ? w_data    : '0;
    assign sram_write_byte_en = w_fire ? w_byte_en : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_resp_val   = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    w_next_state = ST_CAPT;
                end
            end
            ST_CAPT: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_resp_val[r_owner] = !reset;
                if ((r_owner ? resp1_rdy : resp0_rdy)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Read data is captured the cycle after the SRAM was enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= 1'b0;
            r_type      <= REQ_READ;
            r_resp_data <= '0;
        end else begin
            if (w_fire) begin
                r_owner <= w_sel;
                r_type  <= w_type;
            end
            if (r_state == ST_CAPT) begin
                r_resp_data <= (r_type == REQ_WRITE) ? '0 : sram_read_data;
            end
        end
    end

    assign resp0_val  = w_resp_val[0];
    assign resp1_val  = w_resp_val[1];
    assign resp0_type = r_type;
    assign resp1_type = r_type;
    assign resp0_data = r_resp_data;
    assign resp1_data = r_resp_data;

endmodule
